program_loader: RTL and testbench

Loads a program image from a byte-stream host link into the CPU's 16×8 RAM, holding the CPU in halt while it does so. It is the writer side of the RAM the CPU's fetch cycle reads. It drives the RAM write port (address, data, write enable) in place of the CPU's MAR/bus path. It releases the CPU once a complete, valid image has been written.

---
 rtl/program_loader.sv | 175 +++++++++++++++++
 tb/tb_program_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Host-link program loader: streams a length-prefixed image into the CPU's RAM while holding the CPU halted.
// Optional trailing checksum byte is enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // One extra counter bit lets a full-depth image terminate without wrapping.
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    S_CSUM  = 3'd3,
`else
    S_FLUSH = 3'd3,
`endif
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               xfer;
  logic               len_ok;
  logic               start_ok;
  logic [CNT_W-1:0]   cnt_inc;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]  sum_q, sum_d;
  logic [DATA_W-1:0]  sum_total;
`endif

  assign xfer     = in_valid && in_ready;
  assign len_ok   = (in_data != '0) && (in_data <= DATA_W'(2 ** ADDR_W));
  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_ERR));
  assign cnt_inc  = cnt_q + CNT_W'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign sum_total = sum_q + in_data;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LEN;
      S_LEN:  if (xfer) state_d = len_ok ? S_DATA : S_ERR;
      S_DATA: begin
        if (xfer && (cnt_inc == len_q)) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_FLUSH;
`endif
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CSUM: if (xfer) state_d = (sum_total == '0) ? S_DONE : S_ERR;
`else
      // Lets the final RAM write land before done is raised.
      S_FLUSH: state_d = S_DONE;
`endif
      S_DONE: state_d = S_IDLE;
      S_ERR:  if (start) state_d = S_LEN;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the state register
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    cpu_halt = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    error    = (state_q == S_ERR);
    case (state_q)
      S_LEN, S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Write-port, counter and accumulator next-state
  always_comb begin
    cnt_d       = cnt_q;
    len_d       = len_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    if (start_ok) begin
      cnt_d = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_d = '0;
`endif
    end
    if ((state_q == S_LEN) && xfer) begin
      len_d = in_data[CNT_W-1:0];
    end
    if ((state_q == S_DATA) && xfer) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = cnt_q[ADDR_W-1:0];
      mem_wdata_d = in_data;
      cnt_d       = cnt_inc;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_d       = sum_total;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      len_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frame timing, full-depth image, length errors, abort by reset.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       cpu_halt;
  logic       busy;
  logic       done;
  logic       error;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [3:0] log_addr[$];
  logic [7:0] log_data[$];

  program_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .cpu_halt(cpu_halt), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // RAM-side view: every write the RAM would capture, plus done pulses.
  always @(posedge clk) begin
    if (mem_we) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_cpu_halt"}, cpu_halt, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  initial begin
    int n0;
    int d0;
    int bad;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_reset_outputs("reset");

    // Frame 03 A1 B2 C3 at one byte per cycle
    start = 1'b1; tick(); start = 1'b0;
    chk("f1_ready_len", in_ready, 1);
    chk("f1_halt_len", cpu_halt, 1);
    chk("f1_busy_len", busy, 1);
    in_valid = 1'b1; in_data = 8'h03; tick();
    chk("f1_no_we_len", mem_we, 0);
    in_data = 8'hA1; tick();
    chk("f1_w0", {mem_we, mem_addr, mem_wdata}, {1'b1, 4'd0, 8'hA1});
    in_data = 8'hB2; tick();
    chk("f1_w1", {mem_we, mem_addr, mem_wdata}, {1'b1, 4'd1, 8'hB2});
    in_data = 8'hC3; tick();
    chk("f1_w2", {mem_we, mem_addr, mem_wdata}, {1'b1, 4'd2, 8'hC3});
    chk("f1_done_early", done, 0);
    chk("f1_halt_tail", cpu_halt, 1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    in_data = 8'hEA; tick();
    in_valid = 1'b0;
    chk("f1_done", done, 1);
    chk("f1_no_we_done", mem_we, 0);
    tick();
`else
    chk("f1_ready_tail", in_ready, 0);
    in_data = 8'hEE; tick();
    chk("f1_done", done, 1);
    chk("f1_no_we_done", mem_we, 0);
    chk("f1_halt_done", cpu_halt, 1);
    tick();
    in_valid = 1'b0;
`endif
    chk("f1_done_gone", done, 0);
    chk("f1_halt_released", cpu_halt, 0);
    chk("f1_done_count", done_cnt, 1);
    chk("f1_write_count", log_addr.size(), 3);
    tick();
    chk("f1_no_extra_write", log_addr.size(), 3);

    // Full 16-byte image with in_valid toggling
    n0 = log_addr.size(); d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 8'h10; tick();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b0; tick();
      in_valid = 1'b1; in_data = 8'(i); tick();
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    in_data = 8'h88; tick();
`endif
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("n16_write_count", log_addr.size() - n0, 16);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if ((n0 + i) < log_addr.size()) begin
        if (log_addr[n0 + i] !== 4'(i) || log_data[n0 + i] !== 8'(i)) bad++;
      end else begin
        bad++;
      end
    end
    chk("n16_addr_data_seq", bad, 0);
    chk("n16_done", done_cnt - d0, 1);
    chk("n16_halt_released", cpu_halt, 0);

    // Length 00 -> error, no writes
    n0 = log_addr.size(); d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 8'h00; tick();
    in_valid = 1'b0; tick();
    chk("len0_error", error, 1);
    chk("len0_halt", cpu_halt, 1);
    chk("len0_ready", in_ready, 0);
    tick(); tick();
    chk("len0_sticky", error, 1);
    // Length 11 -> error; restart clears the flag
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_clears_error", error, 0);
    chk("restart_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_valid = 1'b0; tick();
    chk("len17_error", error, 1);
    chk("len17_halt", cpu_halt, 1);
    chk("len_err_no_writes", log_addr.size() - n0, 0);
    chk("len_err_no_done", done_cnt - d0, 0);
    // Valid one-byte frame after error
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 8'h01; tick();
    in_data = 8'h5A; tick();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    in_data = 8'hA6; tick();
`endif
    in_valid = 1'b0;
    tick(); tick();
    chk("recover_done", done_cnt - d0, 1);
    chk("recover_error", error, 0);
    chk("recover_write", {log_addr[log_addr.size() - 1], log_data[log_data.size() - 1]}, {4'd0, 8'h5A});

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Bad checksum: writes land, then error
    n0 = log_addr.size(); d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 8'h02; tick();
    in_data = 8'h10; tick();
    in_data = 8'h20; tick();
    in_data = 8'h00; tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("csum_writes", log_addr.size() - n0, 2);
    chk("csum_error", error, 1);
    chk("csum_no_done", done_cnt - d0, 0);
`endif

    // Reset mid-load; start inside DATA is ignored
    n0 = log_addr.size(); d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 8'h04; tick();
    in_data = 8'hD0; tick();
    in_data = 8'hD1; start = 1'b1; tick(); start = 1'b0;
    chk("midload_start_ignored_ready", in_ready, 1);
    chk("midload_w1", {mem_we, mem_addr, mem_wdata}, {1'b1, 4'd1, 8'hD1});
    in_data = 8'hD2; rst = 1'b1; tick(); rst = 1'b0;
    in_valid = 1'b0;
    chk_reset_outputs("abort");
    tick(); tick();
    chk("abort_write_count", log_addr.size() - n0, 2);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle_ready", in_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
